// File: rtl/spi_master_ctrl.sv
// Command-driven SPI master for the SPI wrapper: serialises {op,data} frames on SS_n/MOSI
// and, for read-data frames, captures the returned byte from MISO.
module spi_master_ctrl #(
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned IDLE_GAP   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    TURN,
    CAPTURE,
    STOP
  } state_t;

  localparam logic [3:0] SHIFT_LAST = 4'd9;
  localparam logic [3:0] CAP_LAST   = 4'd7;
  localparam logic [3:0] TURN_LAST  = 4'(TURNAROUND - 1);
  localparam logic [3:0] GAP_LAST   = 4'(IDLE_GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] sh_q, sh_d;
  logic [7:0] cap_q, cap_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       is_rd_q, is_rd_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       rd_valid_q, rd_valid_d;
  logic       handshake;

  assign cmd_ready = (state_q == IDLE) && rst_n;
  assign handshake = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE);
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

  // SS_n/MOSI are registered from the next-state decision so they line up with the state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    cap_d      = cap_q;
    rd_data_d  = rd_data_q;
    is_rd_d    = is_rd_q;
    ss_n_d     = 1'b1;
    mosi_d     = 1'b0;
    rd_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = START;
          sh_d    = {cmd_op, cmd_data};
          is_rd_d = (cmd_op == 2'b11);
          cnt_d   = '0;
          ss_n_d  = 1'b0;
          mosi_d  = cmd_op[1];
        end
      end
      START: begin
        state_d = SHIFT;
        cnt_d   = '0;
        ss_n_d  = 1'b0;
        mosi_d  = sh_q[9];
        sh_d    = {sh_q[8:0], 1'b0};
      end
      SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = '0;
          if (is_rd_q) begin
            state_d = TURN;
            ss_n_d  = 1'b0;
          end else begin
            state_d = STOP;
          end
        end else begin
          cnt_d  = cnt_q + 4'd1;
          ss_n_d = 1'b0;
          mosi_d = sh_q[9];
          sh_d   = {sh_q[8:0], 1'b0};
        end
      end
      TURN: begin
        ss_n_d = 1'b0;
        if (cnt_q == TURN_LAST) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CAPTURE: begin
        cap_d = {cap_q[6:0], MISO};
        if (cnt_q == CAP_LAST) begin
          state_d    = STOP;
          cnt_d      = '0;
          rd_data_d  = {cap_q[6:0], MISO};
          rd_valid_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          ss_n_d = 1'b0;
        end
      end
      STOP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      cap_q      <= '0;
      rd_data_q  <= '0;
      is_rd_q    <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      cap_q      <= cap_d;
      rd_data_q  <= rd_data_d;
      is_rd_q    <= is_rd_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl with hand-computed frame expectations.
module tb_spi_master_ctrl;

  localparam int TURN = 1;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  int total = 0;
  int bad   = 0;

  spi_master_ctrl #(.TURNAROUND(TURN), .IDLE_GAP(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", 64'(cmd_ready), 64'd1);
  endtask

  // Issues one command and observes the whole frame; samples are taken 1 time unit after posedge.
  task automatic run_frame(input logic [1:0] op, input logic [7:0] d, input logic [7:0] miso_b,
                           output logic [31:0] seq, output int low, output int rv,
                           output int bad_mosi);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    seq = '0; low = 0; rv = 0; bad_mosi = 0;
    for (int i = 0; i < 60; i++) begin
      if (rd_valid) rv++;
      if (!SS_n) begin
        seq = {seq[30:0], MOSI};
        if (low >= 11 + TURN && low < 19 + TURN) MISO = miso_b[7 - (low - 11 - TURN)];
        else MISO = 1'b0;
        low++;
      end else begin
        if (MOSI) bad_mosi++;
        if (low > 0) break;
      end
      @(posedge clk); #1;
    end
    MISO = 1'b0;
  endtask

  initial begin
    logic [31:0] seq;
    int          low, rv, bm, sv;
    logic [37:0] ss_v, rdy_v, exp_ss, exp_rdy;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; MISO = 1'b0;
    #12;
    check("rst_ss_n", 64'(SS_n), 64'd1);
    check("rst_mosi", 64'(MOSI), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'h00);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // wr_addr 0x3C: MOSI 0,0,0,0,0,1,1,1,1,0,0
    run_frame(2'b00, 8'h3C, 8'h00, seq, low, rv, bm);
    check("wa_low", 64'(low), 64'd11);
    check("wa_mosi", 64'(seq), 64'h03C);
    check("wa_rv", 64'(rv), 64'd0);
    check("wa_mosi_hi", 64'(bm), 64'd0);
    check("wa_ready_stop", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    check("wa_ready_back", 64'(cmd_ready), 64'd1);

    // wr_data 0xA5: MOSI 0,0,1,1,0,1,0,0,1,0,1
    run_frame(2'b01, 8'hA5, 8'h00, seq, low, rv, bm);
    check("wd_low", 64'(low), 64'd11);
    check("wd_mosi", 64'(seq), 64'h1A5);
    check("wd_rv", 64'(rv), 64'd0);

    // rd_addr 0x3C: MOSI 1,1,0,0,0,1,1,1,1,0,0
    run_frame(2'b10, 8'h3C, 8'h00, seq, low, rv, bm);
    check("ra_low", 64'(low), 64'd11);
    check("ra_mosi", 64'(seq), 64'h63C);

    // rd_data, slave returns 0xA5; command bits 1,1,1 then zeros for the remaining 17 cycles
    run_frame(2'b11, 8'h00, 8'hA5, seq, low, rv, bm);
    check("rd1_low", 64'(low), 64'd20);
    check("rd1_mosi", 64'(seq), 64'hE0000);
    check("rd1_rv", 64'(rv), 64'd1);
    check("rd1_data", 64'(rd_data), 64'hA5);
    check("rd1_mosi_hi", 64'(bm), 64'd0);

    // idle stability with MISO toggling
    sv = 0;
    for (int i = 0; i < 50; i++) begin
      MISO = ~MISO;
      @(posedge clk); #1;
      if (!SS_n || MOSI || rd_valid || busy) sv++;
    end
    MISO = 1'b0;
    check("idle_viol", 64'(sv), 64'd0);
    check("idle_rd_data", 64'(rd_data), 64'hA5);

    // second read-data frame: all-ones command byte, slave returns 0x5A
    run_frame(2'b11, 8'hFF, 8'h5A, seq, low, rv, bm);
    check("rd2_low", 64'(low), 64'd20);
    check("rd2_mosi", 64'(seq), 64'hFFE00);
    check("rd2_rv", 64'(rv), 64'd1);
    check("rd2_data", 64'(rd_data), 64'h5A);

    // back-to-back: period = 11 low + GAP stop + 1 idle = 13 cycles
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h3C;
    for (int t = 0; t < 38; t++) begin
      ss_v[t]    = SS_n;
      rdy_v[t]   = cmd_ready;
      exp_ss[t]  = 1'b1;
      exp_rdy[t] = (t % 13 == 0);
      for (int j = 0; j < 3; j++)
        if (t >= 1 + 13 * j && t <= 11 + 13 * j) exp_ss[t] = 1'b0;
      if (t == 37) cmd_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b_ss_n", 64'(ss_v), 64'(exp_ss));
    check("b2b_ready", 64'(rdy_v), 64'(exp_rdy));

    // reset at SHIFT bit 5 of a read-data frame
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'h81;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    check("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ss_n", 64'(SS_n), 64'd1);
    check("mid_rst_mosi", 64'(MOSI), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rd_data", 64'(rd_data), 64'h00);
    sv = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rd_valid) sv++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (rd_valid || !SS_n) sv++;
    end
    check("mid_no_rv", 64'(sv), 64'd0);
    run_frame(2'b00, 8'h3C, 8'h00, seq, low, rv, bm);
    check("post_low", 64'(low), 64'd11);
    check("post_mosi", 64'(seq), 64'h03C);
    check("post_rv", 64'(rv), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
